// File: rtl/atm_ram_pkg.sv
// Shared widths, RAM word field slices, op/status codes and FSM encodings
// for the account RAM transaction controller.
package atm_ram_pkg;
  localparam int FINAL_UP_LIMIT_WIDTH   = 15;
  localparam int AVAILABLE_CREDIT_WIDTH = 25;
  localparam int RAM_DATA_WIDTH         = FINAL_UP_LIMIT_WIDTH + AVAILABLE_CREDIT_WIDTH;
  localparam int RAM_MEM_SIZE           = 64;
  localparam int ADDR_W                 = $clog2(RAM_MEM_SIZE);

  localparam int LIMIT_MSB  = RAM_DATA_WIDTH - 1;
  localparam int LIMIT_LSB  = AVAILABLE_CREDIT_WIDTH;
  localparam int CREDIT_MSB = AVAILABLE_CREDIT_WIDTH - 1;
  localparam int CREDIT_LSB = 0;

  typedef enum logic [1:0] {
    OP_QUERY    = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_NO_CREDIT  = 2'b01,
    ST_OVER_LIMIT = 2'b10,
    ST_BAD        = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_EXEC = 2'b10,
    S_RSP  = 2'b11
  } state_e;

  typedef struct packed {
    logic                              src;
    op_e                               op;
    logic [ADDR_W-1:0]                 acct;
    logic [AVAILABLE_CREDIT_WIDTH-1:0] amount;
    logic [RAM_DATA_WIDTH-1:0]         word;
  } req_t;
endpackage

// File: rtl/atm_ram_txn_ctrl_if.sv
// ATM transaction, admin config and response handshakes of the account
// RAM controller. master = requester side, slave = controller side.
interface atm_ram_txn_ctrl_if;
  import atm_ram_pkg::*;

  logic                              txn_valid;
  logic                              txn_ready;
  logic [1:0]                        txn_op;
  logic [ADDR_W-1:0]                 txn_account;
  logic [AVAILABLE_CREDIT_WIDTH-1:0] txn_amount;

  logic                              cfg_valid;
  logic                              cfg_ready;
  logic [ADDR_W-1:0]                 cfg_account;
  logic [RAM_DATA_WIDTH-1:0]         cfg_word;

  logic                              rsp_valid;
  logic                              rsp_ready;
  logic                              rsp_src;
  logic [1:0]                        rsp_status;
  logic [AVAILABLE_CREDIT_WIDTH-1:0] rsp_credit;
  logic [FINAL_UP_LIMIT_WIDTH-1:0]   rsp_limit;

  modport master (
    output txn_valid, txn_op, txn_account, txn_amount,
    output cfg_valid, cfg_account, cfg_word, rsp_ready,
    input  txn_ready, cfg_ready,
    input  rsp_valid, rsp_src, rsp_status, rsp_credit, rsp_limit
  );

  modport slave (
    input  txn_valid, txn_op, txn_account, txn_amount,
    input  cfg_valid, cfg_account, cfg_word, rsp_ready,
    output txn_ready, cfg_ready,
    output rsp_valid, rsp_src, rsp_status, rsp_credit, rsp_limit
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0] = ATM txn, req[1] = cfg.
// Priority pointer resets to favour req[0].
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q;  // 1 = req[1] wins a tie

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  // After a grant the other requester gets priority on the next tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= 1'b0;
    else if (advance) ptr_q <= gnt[0];
  end
endmodule

// File: rtl/atm_ram_txn_ctrl.sv
// Account RAM sequencer: arbitrates ATM/admin requests, does checked RMW.
// Optional: define ATM_CTRL_LIMIT_CHECK_EN to enable the per-withdrawal limit check.
module atm_ram_txn_ctrl
  import atm_ram_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  atm_ram_txn_ctrl_if.slave         bus,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rdata
);
  state_e state_q, state_d;
  req_t   req_q;
  logic [RAM_DATA_WIDTH-1:0] word_q;
  logic [1:0] gnt;
  logic       accept;

  logic                              rsp_src_q;
  status_e                           rsp_status_q;
  logic [AVAILABLE_CREDIT_WIDTH-1:0] rsp_credit_q;
  logic [FINAL_UP_LIMIT_WIDTH-1:0]   rsp_limit_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.cfg_valid, bus.txn_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign bus.txn_ready = (state_q == S_IDLE) & gnt[0];
  assign bus.cfg_ready = (state_q == S_IDLE) & gnt[1];
  assign accept        = (state_q == S_IDLE) & (|gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RD;
      S_RD:   state_d = S_EXEC;
      S_EXEC: state_d = S_RSP;
      S_RSP:  if (bus.rsp_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      word_q <= '0;
    end else begin
      if (accept) begin
        req_q.src    <= gnt[1];
        req_q.op     <= op_e'(bus.txn_op);
        req_q.acct   <= gnt[1] ? bus.cfg_account : bus.txn_account;
        req_q.amount <= bus.txn_amount;
        req_q.word   <= bus.cfg_word;
      end
      if (state_q == S_RD) word_q <= ram_rdata;
    end
  end

  // Read-modify-write datapath, evaluated during EXEC
  logic [AVAILABLE_CREDIT_WIDTH-1:0] credit;
  logic [FINAL_UP_LIMIT_WIDTH-1:0]   limit;
  logic [AVAILABLE_CREDIT_WIDTH:0]   sum;
  logic                              over_limit;
  logic                              commit;
  status_e                           status;
  logic [RAM_DATA_WIDTH-1:0]         new_word;

  assign credit = word_q[CREDIT_MSB:CREDIT_LSB];
  assign limit  = word_q[LIMIT_MSB:LIMIT_LSB];
  assign sum    = {1'b0, credit} + {1'b0, req_q.amount};

`ifdef ATM_CTRL_LIMIT_CHECK_EN
  assign over_limit = req_q.amount >
                      {{(AVAILABLE_CREDIT_WIDTH-FINAL_UP_LIMIT_WIDTH){1'b0}}, limit};
`else
  assign over_limit = 1'b0;
`endif

  always_comb begin
    commit   = 1'b0;
    status   = ST_OK;
    new_word = word_q;
    if (req_q.src) begin
      commit   = 1'b1;
      new_word = req_q.word;
    end else begin
      unique case (req_q.op)
        OP_QUERY: ;
        OP_WITHDRAW: begin
          if (over_limit)                 status = ST_OVER_LIMIT;
          else if (req_q.amount > credit) status = ST_NO_CREDIT;
          else begin
            commit   = 1'b1;
            new_word = {limit, credit - req_q.amount};
          end
        end
        OP_DEPOSIT: begin
          if (sum[AVAILABLE_CREDIT_WIDTH]) status = ST_BAD;
          else begin
            commit   = 1'b1;
            new_word = {limit, sum[AVAILABLE_CREDIT_WIDTH-1:0]};
          end
        end
        default: status = ST_BAD;
      endcase
    end
  end

  // Decoded from state so reset kills the write strobe asynchronously
  assign ram_we    = (state_q == S_EXEC) & commit;
  assign ram_wdata = ram_we ? new_word : '0;
  assign ram_addr  = (state_q != S_IDLE) ? req_q.acct : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_src_q    <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_credit_q <= '0;
      rsp_limit_q  <= '0;
    end else if (state_q == S_EXEC) begin
      rsp_src_q    <= req_q.src;
      rsp_status_q <= status;
      rsp_credit_q <= new_word[CREDIT_MSB:CREDIT_LSB];
      rsp_limit_q  <= new_word[LIMIT_MSB:LIMIT_LSB];
    end
  end

  assign bus.rsp_valid  = (state_q == S_RSP);
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_credit = rsp_credit_q;
  assign bus.rsp_limit  = rsp_limit_q;
endmodule

// File: tb/tb_atm_ram_txn_ctrl.sv
// Directed self-checking bench for atm_ram_txn_ctrl with a behavioural
// 64x40 account RAM (comb read, posedge write).
module tb_atm_ram_txn_ctrl;
  import atm_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [RAM_DATA_WIDTH-1:0] ram_wdata;
  logic [RAM_DATA_WIDTH-1:0] ram_rdata;
  logic [RAM_DATA_WIDTH-1:0] mem [0:RAM_MEM_SIZE-1];
  int we_cnt = 0;

  atm_ram_txn_ctrl_if bus ();

  atm_ram_txn_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0]  r_status;
  logic [24:0] r_credit;
  logic [14:0] r_limit;
  logic        r_src;
  int          r_writes;
  int          r_lat;

  localparam logic [24:0] CMAX = 25'h1FF_FFFF;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request: accept, wait for response, handshake it
  task automatic run(input logic is_cfg, input logic [1:0] op, input int acct,
                     input logic [24:0] amt, input logic [39:0] word);
    bit ok = 0;
    int w0;
    @(negedge clk);
    w0 = we_cnt;
    bus.txn_valid = !is_cfg; bus.cfg_valid = is_cfg;
    bus.txn_op = op; bus.txn_account = ADDR_W'(acct); bus.txn_amount = amt;
    bus.cfg_account = ADDR_W'(acct); bus.cfg_word = word;
    #1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (is_cfg ? bus.cfg_ready : bus.txn_ready) begin
        @(posedge clk); ok = 1;
      end else @(negedge clk);
    end
    #1;
    bus.txn_valid = 1'b0; bus.cfg_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL accept_timeout: ready never seen, want accept within 20 cycles");
    end
    r_lat = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); r_lat++;
      if (bus.rsp_valid) ok = 1;
    end
    if (!ok) begin
      total_cnt++;
      $display("FAIL rsp_timeout: rsp_valid never seen, want response within 20 cycles");
    end
    r_status = bus.rsp_status; r_credit = bus.rsp_credit;
    r_limit = bus.rsp_limit; r_src = bus.rsp_src;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    r_writes = we_cnt - w0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.txn_ready !== 1'b0) $display("FAIL rst_txn_ready: got %b want 0", bus.txn_ready); else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else pass_cnt++;
    total_cnt++; if (ram_addr !== '0) $display("FAIL rst_ram_addr: got %0d want 0", ram_addr); else pass_cnt++;
    total_cnt++; if (bus.rsp_credit !== '0) $display("FAIL rst_rsp_credit: got %0d want 0", bus.rsp_credit); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_withdraw();
    run(1, 2'b00, 5, 25'd0, {15'd1000, 25'd5000});
    total_cnt++; if (r_src !== 1'b1 || r_credit !== 25'd5000 || r_writes != 1)
      $display("FAIL cfg_load: src %b credit %0d writes %0d want 1 5000 1", r_src, r_credit, r_writes); else pass_cnt++;
    run(0, OP_WITHDRAW, 5, 25'd800, '0);
    total_cnt++; if (r_status !== ST_OK) $display("FAIL wd_status: got %0d want 0", r_status); else pass_cnt++;
    total_cnt++; if (r_credit !== 25'd4200) $display("FAIL wd_credit: got %0d want 4200", r_credit); else pass_cnt++;
    total_cnt++; if (r_limit !== 15'd1000) $display("FAIL wd_limit: got %0d want 1000", r_limit); else pass_cnt++;
    total_cnt++; if (r_src !== 1'b0) $display("FAIL wd_src: got %b want 0", r_src); else pass_cnt++;
    total_cnt++; if (r_lat != 3) $display("FAIL wd_latency: got %0d want 3", r_lat); else pass_cnt++;
    total_cnt++; if (mem[5] !== {15'd1000, 25'd4200}) $display("FAIL wd_ram: got %h want %h", mem[5], {15'd1000, 25'd4200}); else pass_cnt++;
  endtask

  task automatic test_over_limit();
    run(0, OP_WITHDRAW, 5, 25'd1200, '0);
`ifdef ATM_CTRL_LIMIT_CHECK_EN
    total_cnt++; if (r_status !== ST_OVER_LIMIT) $display("FAIL ol_status: got %0d want 2", r_status); else pass_cnt++;
    total_cnt++; if (r_credit !== 25'd4200) $display("FAIL ol_credit: got %0d want 4200", r_credit); else pass_cnt++;
    total_cnt++; if (r_writes != 0) $display("FAIL ol_writes: got %0d want 0", r_writes); else pass_cnt++;
`else
    total_cnt++; if (r_status !== ST_OK) $display("FAIL nolim_status: got %0d want 0", r_status); else pass_cnt++;
    total_cnt++; if (r_credit !== 25'd3000) $display("FAIL nolim_credit: got %0d want 3000", r_credit); else pass_cnt++;
    total_cnt++; if (r_writes != 1) $display("FAIL nolim_writes: got %0d want 1", r_writes); else pass_cnt++;
`endif
    run(0, OP_QUERY, 5, 25'd7, '0);
    total_cnt++; if (r_writes != 0 || r_limit !== 15'd1000) $display("FAIL query: writes %0d limit %0d want 0 1000", r_writes, r_limit); else pass_cnt++;
  endtask

  task automatic test_credit_edge();
    run(1, 2'b00, 9, 25'd0, {15'd500, 25'd300});
    run(0, OP_WITHDRAW, 9, 25'd300, '0);
    total_cnt++; if (r_status !== ST_OK || r_credit !== 25'd0) $display("FAIL exact_wd: status %0d credit %0d want 0 0", r_status, r_credit); else pass_cnt++;
    total_cnt++; if (r_writes != 1) $display("FAIL exact_wd_writes: got %0d want 1", r_writes); else pass_cnt++;
    run(0, OP_WITHDRAW, 9, 25'd1, '0);
    total_cnt++; if (r_status !== ST_NO_CREDIT || r_credit !== 25'd0) $display("FAIL no_credit: status %0d credit %0d want 1 0", r_status, r_credit); else pass_cnt++;
    total_cnt++; if (r_writes != 0) $display("FAIL no_credit_writes: got %0d want 0", r_writes); else pass_cnt++;
  endtask

  task automatic test_deposit();
    run(1, 2'b00, 12, 25'd0, {15'd77, CMAX - 25'd9});
    run(0, OP_DEPOSIT, 12, 25'd20, '0);
    total_cnt++; if (r_status !== ST_BAD || r_credit !== CMAX - 25'd9) $display("FAIL dep_ovf: status %0d credit %0d want 3 %0d", r_status, r_credit, CMAX - 25'd9); else pass_cnt++;
    total_cnt++; if (r_writes != 0) $display("FAIL dep_ovf_writes: got %0d want 0", r_writes); else pass_cnt++;
    run(0, OP_DEPOSIT, 12, 25'd9, '0);
    total_cnt++; if (r_status !== ST_OK || r_credit !== CMAX) $display("FAIL dep_max: status %0d credit %0d want 0 %0d", r_status, r_credit, CMAX); else pass_cnt++;
    total_cnt++; if (mem[12] !== {15'd77, CMAX}) $display("FAIL dep_ram: got %h want %h", mem[12], {15'd77, CMAX}); else pass_cnt++;
    run(0, OP_RSVD, 12, 25'd1, '0);
    total_cnt++; if (r_status !== ST_BAD || r_writes != 0) $display("FAIL bad_op: status %0d writes %0d want 3 0", r_status, r_writes); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    @(negedge clk);
    bus.txn_valid = 1'b1; bus.txn_op = OP_QUERY; bus.txn_account = 6'd5; bus.txn_amount = '0;
    bus.cfg_valid = 1'b1; bus.cfg_account = 6'd20; bus.cfg_word = {15'd3, 25'd44};
    for (int k = 0; k < 4; k++) begin
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (bus.rsp_valid) ok = 1;
      end
      total_cnt++;
      if (!ok) $display("FAIL rr_timeout_%0d: no response, want one", k);
      else if (bus.rsp_src !== k[0]) $display("FAIL rr_src_%0d: got %b want %b", k, bus.rsp_src, k[0]);
      else pass_cnt++;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      if (k == 3) begin bus.txn_valid = 1'b0; bus.cfg_valid = 1'b0; end
    end
  endtask

  task automatic test_reset_mid_op();
    int w0;
    run(1, 2'b00, 7, 25'd0, {15'd1000, 25'd500});
    @(negedge clk);
    bus.txn_valid = 1'b1; bus.txn_op = OP_WITHDRAW; bus.txn_account = 6'd7; bus.txn_amount = 25'd100;
    @(posedge clk); #1;
    bus.txn_valid = 1'b0;
    @(posedge clk); #1;
    w0 = we_cnt;
    total_cnt++; if (ram_we !== 1'b1) $display("FAIL exec_we: got %b want 1", ram_we); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (ram_we !== 1'b0) $display("FAIL abort_we: got %b want 0", ram_we); else pass_cnt++;
    total_cnt++; if (ram_addr !== '0 || bus.rsp_valid !== 1'b0 || bus.txn_ready !== 1'b0)
      $display("FAIL abort_outs: addr %0d rsp_valid %b ready %b want 0 0 0", ram_addr, bus.rsp_valid, bus.txn_ready); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (mem[7] !== {15'd1000, 25'd500} || we_cnt != w0)
      $display("FAIL abort_ram: got %h writes %0d want %h 0", mem[7], we_cnt - w0, {15'd1000, 25'd500}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, OP_QUERY, 7, 25'd0, '0);
    total_cnt++; if (r_credit !== 25'd500) $display("FAIL abort_query: got %0d want 500", r_credit); else pass_cnt++;
  endtask

  initial begin
    bus.txn_valid = 1'b0; bus.txn_op = '0; bus.txn_account = '0; bus.txn_amount = '0;
    bus.cfg_valid = 1'b0; bus.cfg_account = '0; bus.cfg_word = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_withdraw();
    test_over_limit();
    test_credit_edge();
    test_deposit();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
